matrix_feeder: RTL and testbench

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_regfile.sv | 34 +++
 rtl/matrix_feeder.sv | 111 +++++++++++
 tb/tb_matrix_feeder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and pair-order table for the 2x2 matrix operand feeder.
package matrix_pkg;

    localparam int DEF_DW        = 8;
    localparam int MAT_DIM       = 2;
    localparam int DEF_PHASE_LEN = 3;
    localparam int PAIR_CNT      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_FEED = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Returns {x_index, y_index} for pair k; consecutive pairs sum to C00, C01, C10, C11.
    function automatic logic [3:0] pair_sel(input logic [2:0] k);
        logic [3:0] sel;
        case (k)
            3'd0:    sel = 4'b00_00;
            3'd1:    sel = 4'b01_10;
            3'd2:    sel = 4'b00_01;
            3'd3:    sel = 4'b01_11;
            3'd4:    sel = 4'b10_00;
            3'd5:    sel = 4'b11_10;
            3'd6:    sel = 4'b10_01;
            3'd7:    sel = 4'b11_11;
            default: sel = 4'b00_00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/matrix_regfile.sv
// Eight-entry operand store: X at addresses 0-3, Y at 4-7; one write port, two async read ports.
module matrix_regfile
    import matrix_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [2:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    x_idx_i,
    input  logic [1:0]    y_idx_i,
    output logic [DW-1:0] x_rd_o,
    output logic [DW-1:0] y_rd_o
);

    logic [DW-1:0] mem_q [PAIR_CNT];

    // Element storage with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAIR_CNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign x_rd_o = mem_q[{1'b0, x_idx_i}];
    assign y_rd_o = mem_q[{1'b1, y_idx_i}];

endmodule

// File: rtl/matrix_feeder.sv
// Streams the eight X*Y operand pairs of a 2x2 product to a 3-stage multiplier, each held PHASE_LEN cycles.
module matrix_feeder
    import matrix_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int PHASE_LEN = DEF_PHASE_LEN
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD_EN,
    input  logic          LOAD_SEL,
    input  logic [1:0]    LOAD_ADDR,
    input  logic [DW-1:0] LOAD_DATA,
    input  logic          GO,
    output logic          START,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic          BUSY,
    output logic          DONE
);

    localparam int          CW         = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_LEN - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(PAIR_CNT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic          start_q, busy_q, done_q;
    logic [DW-1:0] a_q, b_q;
    logic [3:0]    sel_s;
    logic [DW-1:0] x_rd_s, y_rd_s;
    logic          we_s;

    // Loads are accepted only while idle so a running stream never sees operands change.
    assign we_s  = LOAD_EN && (state_q == ST_IDLE);
    assign sel_s = pair_sel(idx_d);

    matrix_regfile #(.DW(DW)) u_regfile (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (we_s),
        .waddr_i ({LOAD_SEL, LOAD_ADDR}),
        .wdata_i (LOAD_DATA),
        .x_idx_i (sel_s[3:2]),
        .y_idx_i (sel_s[1:0]),
        .x_rd_o  (x_rd_s),
        .y_rd_o  (y_rd_s)
    );

    // Next-state and pair/phase counter logic
    always_comb begin
        state_d = state_q;
        phase_d = '0;
        idx_d   = 3'd0;
        case (state_q)
            ST_IDLE: begin
                if (GO) begin
                    state_d = ST_KICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KICK: state_d = ST_FEED;
            ST_FEED: begin
                if (phase_q == PHASE_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    phase_d = phase_q + CW'(1);
                    idx_d   = idx_q;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs, all derived from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            idx_q   <= 3'd0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            start_q <= (state_d == ST_KICK);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN);
            a_q     <= (state_d == ST_FEED) ? x_rd_s : '0;
            b_q     <= (state_d == ST_FEED) ? y_rd_s : '0;
        end
    end

    assign START = start_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign A     = a_q;
    assign B     = b_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed self-checking bench for matrix_feeder with hand-computed operand streams and dot products.
module tb_matrix_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       LOAD_EN = 1'b0;
    logic       LOAD_SEL = 1'b0;
    logic [1:0] LOAD_ADDR = 2'd0;
    logic [7:0] LOAD_DATA = 8'd0;
    logic       GO = 1'b0;
    logic       START, BUSY, DONE;
    logic [7:0] A, B;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ea [8];
    int eb [8];
    int ec [4];

    matrix_feeder dut (
        .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_SEL(LOAD_SEL),
        .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .GO(GO),
        .START(START), .A(A), .B(B), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [1:0] addr, input logic [7:0] data);
        LOAD_EN = 1'b1; LOAD_SEL = sel; LOAD_ADDR = addr; LOAD_DATA = data;
        step();
        LOAD_EN = 1'b0;
    endtask

    // inj: 0 none, 1 extra GO at cycles 5 and 20, 2 write X00=9 during FEED
    task automatic run(input int inj);
        int acc;
        int k;
        acc = 0;
        GO = 1'b1;
        step();
        GO = 1'b0; LOAD_EN = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            cyc = c;
            k = (c - 2) / 3;
            chk("START", 32'(START), 32'(c == 1));
            chk("BUSY", 32'(BUSY), 32'd1);
            chk("DONE", 32'(DONE), 32'(c == 26));
            if (c >= 2 && c <= 25) begin
                chk("A", 32'(A), 32'(ea[k] & 255));
                chk("B", 32'(B), 32'(eb[k] & 255));
                if ((c - 2) % 3 == 0) begin
                    acc += int'($signed(A)) * int'($signed(B));
                    if (k % 2 == 1) begin
                        chk("STROBE", 32'(acc), 32'(ec[k / 2]));
                        acc = 0;
                    end
                end
            end else begin
                chk("A_ZERO", 32'(A), 32'd0);
                chk("B_ZERO", 32'(B), 32'd0);
            end
            GO = (inj == 1) && (c == 5 || c == 20);
            LOAD_EN = (inj == 2) && (c == 8);
            LOAD_SEL = 1'b0; LOAD_ADDR = 2'd0; LOAD_DATA = 8'd9;
            step();
            GO = 1'b0; LOAD_EN = 1'b0;
        end
        cyc = 27;
        chk("BUSY_END", 32'(BUSY), 32'd0);
        chk("DONE_END", 32'(DONE), 32'd0);
        chk("START_END", 32'(START), 32'd0);
    endtask

    initial begin
        // Reset with GO and LOAD_EN held high: reset must win
        RST = 1'b1; GO = 1'b1; LOAD_EN = 1'b1; LOAD_DATA = 8'h55;
        step(); step();
        chk("RST_START", 32'(START), 32'd0);
        chk("RST_BUSY", 32'(BUSY), 32'd0);
        chk("RST_DONE", 32'(DONE), 32'd0);
        chk("RST_A", 32'(A), 32'd0);
        chk("RST_B", 32'(B), 32'd0);
        RST = 1'b0; GO = 1'b0; LOAD_EN = 1'b0;
        step();
        chk("IDLE_BUSY", 32'(BUSY), 32'd0);

        // Basic product X=[1 2;3 4], Y=[5 6;7 8]
        load(1'b0, 2'd0, 8'd1); load(1'b0, 2'd1, 8'd2);
        load(1'b0, 2'd2, 8'd3); load(1'b0, 2'd3, 8'd4);
        load(1'b1, 2'd0, 8'd5); load(1'b1, 2'd1, 8'd6);
        load(1'b1, 2'd2, 8'd7); load(1'b1, 2'd3, 8'd8);
        ea = '{1, 2, 1, 2, 3, 4, 3, 4};
        eb = '{5, 7, 6, 8, 5, 7, 6, 8};
        ec = '{19, 22, 43, 50};
        run(0);

        // GO while busy is ignored
        step();
        run(1);
        step();
        chk("NO_REQUEUE", 32'(BUSY), 32'd0);

        // Load while busy is ignored, stays ignored on the read-back run
        run(2);
        step();
        run(0);
        load(1'b0, 2'd0, 8'd9);
        ea = '{9, 2, 9, 2, 3, 4, 3, 4};
        ec = '{59, 70, 43, 50};
        run(0);

        // Reset mid-run at cycle 10
        GO = 1'b1;
        step();
        GO = 1'b0;
        for (int c = 1; c < 10; c++) step();
        cyc = 10;
        chk("PRE_RST_BUSY", 32'(BUSY), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        cyc = 11;
        chk("ABORT_A", 32'(A), 32'd0);
        chk("ABORT_B", 32'(B), 32'd0);
        chk("ABORT_BUSY", 32'(BUSY), 32'd0);
        chk("ABORT_START", 32'(START), 32'd0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("ABORT_NODONE", 32'(DONE), 32'd0);
        end
        ea = '{0, 0, 0, 0, 0, 0, 0, 0};
        eb = '{0, 0, 0, 0, 0, 0, 0, 0};
        ec = '{0, 0, 0, 0};
        run(0);

        // Signed extremes
        for (int i = 0; i < 4; i++) begin
            load(1'b0, 2'(i), 8'h80);
            load(1'b1, 2'(i), 8'h80);
        end
        ea = '{-128, -128, -128, -128, -128, -128, -128, -128};
        eb = '{-128, -128, -128, -128, -128, -128, -128, -128};
        ec = '{32768, 32768, 32768, 32768};
        run(0);

        // Load X11=-1 in the same cycle as GO
        LOAD_EN = 1'b1; LOAD_SEL = 1'b0; LOAD_ADDR = 2'd3; LOAD_DATA = 8'hFF;
        ea = '{-128, -128, -128, -128, -128, -1, -128, -1};
        ec = '{32768, 32768, 16512, 16512};
        run(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
